pwm_capture: RTL and testbench

- Receive-side counterpart of the LED PWM generator. Measures the period and high time of an incoming PWM waveform in clk cycles.
- Reports each completed period as a one-cycle result strobe.
- Used to loop back and self-check generator output, and to decode externally supplied PWM dimming inputs.
- Reports 0% and 100% duty, where no edges occur, through a timeout path. A timeout result uses the same duty=0 / duty=period convention as the generator.

---
 rtl/pwm_capture.sv | 114 +++++++++++
 tb/tb_pwm_capture.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk cycles.
// Emits a one-cycle result strobe per full period, plus a timeout result when the input is stuck.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no reference rising edge yet (after reset or after timeout)
// MEASURE | reference rise seen; next rise reports a full period
module pwm_capture #(
    parameter int WIDTH       = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] period_o,
    output logic [WIDTH-1:0] duty_o,
    output logic             valid_o,
    output logic             timeout_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       high_q, high_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [WIDTH-1:0]       duty_q, duty_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    state_t                 state_q, state_d;

    logic s;
    logic rise;
    logic fall;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], pwm_i};
        prev_d    = s;
        cnt_d     = cnt_q;
        high_d    = high_q;
        period_d  = period_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        state_d   = state_q;

        if (rise) begin
            cnt_d = WIDTH'(1);
        end else if (cnt_q != MAX) begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        if (fall && (state_q == MEASURE)) begin
            high_d = cnt_q;
        end

        // A rise beats a simultaneous saturation, so a period of exactly MAX is still reported.
        if (rise) begin
            state_d   = MEASURE;
            timeout_d = 1'b0;
            if (state_q == MEASURE) begin
                period_d = cnt_q;
                duty_d   = high_q;
                valid_d  = 1'b1;
            end
        end else if ((cnt_q == MAX) && !timeout_q) begin
            period_d  = MAX;
            duty_d    = s ? MAX : '0;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            high_q    <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= IDLE;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            state_q   <= state_d;
        end
    end

    assign period_o  = period_q;
    assign duty_o    = duty_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (WIDTH 17 and 8) share one PWM input and are checked
// every cycle against an elapsed-time reference model of the capture rules.
module tb_pwm_capture;

    localparam int SYNC = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        pwm_i = 1'b0;

    logic [16:0] period17, duty17;
    logic        valid17, timeout17;
    logic [7:0]  period8, duty8;
    logic        valid8, timeout8;

    pwm_capture #(.WIDTH(17), .SYNC_STAGES(SYNC)) u_dut17 (
        .clk       (clk),
        .reset     (reset),
        .pwm_i     (pwm_i),
        .period_o  (period17),
        .duty_o    (duty17),
        .valid_o   (valid17),
        .timeout_o (timeout17)
    );

    pwm_capture #(.WIDTH(8), .SYNC_STAGES(SYNC)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .pwm_i     (pwm_i),
        .period_o  (period8),
        .duty_o    (duty8),
        .valid_o   (valid8),
        .timeout_o (timeout8)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: counts elapsed cycles since the last reference rise (or reset).
    int m_max [2] = '{131071, 255};
    int m_c;
    int m_ref  [2];
    int m_high [2];
    bit m_have [2];
    int e_per  [2];
    int e_duty [2];
    bit e_valid[2];
    bit e_to   [2];
    bit hist[$];
    bit prev_s;
    bit cur_pin;

    task automatic model_reset();
        m_c = 0;
        hist.delete();
        for (int k = 0; k < SYNC; k++) hist.push_back(1'b0);
        prev_s  = 1'b0;
        cur_pin = pwm_i;
        for (int i = 0; i < 2; i++) begin
            m_ref[i]   = 0;
            m_high[i]  = 0;
            m_have[i]  = 1'b0;
            e_per[i]   = 0;
            e_duty[i]  = 0;
            e_valid[i] = 1'b0;
            e_to[i]    = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("valid17",   int'(valid17),   int'(e_valid[0]));
        chk("period17",  int'(period17),  e_per[0]);
        chk("duty17",    int'(duty17),    e_duty[0]);
        chk("timeout17", int'(timeout17), int'(e_to[0]));
        chk("valid8",    int'(valid8),    int'(e_valid[1]));
        chk("period8",   int'(period8),   e_per[1]);
        chk("duty8",     int'(duty8),     e_duty[1]);
        chk("timeout8",  int'(timeout8),  int'(e_to[1]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid17"},   int'(valid17),   0);
        chk({tag, "_period17"},  int'(period17),  0);
        chk({tag, "_duty17"},    int'(duty17),    0);
        chk({tag, "_timeout17"}, int'(timeout17), 0);
        chk({tag, "_valid8"},    int'(valid8),    0);
        chk({tag, "_period8"},   int'(period8),   0);
        chk({tag, "_duty8"},     int'(duty8),     0);
        chk({tag, "_timeout8"},  int'(timeout8),  0);
    endtask

    // One clock cycle: check registered outputs, advance the model, then drive the next pin value.
    task automatic step(input bit p);
        bit s, rise, fall;
        int el;
        @(negedge clk);
        check_outputs();
        m_c++;
        hist.push_front(cur_pin);
        void'(hist.pop_back());
        s    = hist[SYNC-1];
        rise = s && !prev_s;
        fall = !s && prev_s;
        for (int i = 0; i < 2; i++) begin
            el = m_c - m_ref[i];
            if (el > m_max[i]) el = m_max[i];
            e_valid[i] = 1'b0;
            if (rise) begin
                if (m_have[i]) begin
                    e_valid[i] = 1'b1;
                    e_per[i]   = el;
                    e_duty[i]  = m_high[i];
                end
                m_have[i] = 1'b1;
                e_to[i]   = 1'b0;
                m_ref[i]  = m_c;
            end else begin
                if (fall && m_have[i]) m_high[i] = el;
                if (el == m_max[i] && !e_to[i]) begin
                    e_valid[i] = 1'b1;
                    e_per[i]   = m_max[i];
                    e_duty[i]  = s ? m_max[i] : 0;
                    e_to[i]    = 1'b1;
                    m_have[i]  = 1'b0;
                end
            end
        end
        prev_s  = s;
        pwm_i   = p;
        cur_pin = p;
    endtask

    task automatic run_pwm(input int per, input int hi, input int n);
        for (int r = 0; r < n; r++)
            for (int k = 0; k < per; k++)
                step(k < hi);
    endtask

    initial begin
        int per, hi;

        // Reset held while the input toggles: nothing may come out.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_zero("in_reset");
            pwm_i = ~pwm_i;
        end
        @(negedge clk);
        pwm_i = 1'b0;
        reset = 1'b1;
        model_reset();

        run_pwm(100, 25, 5);
        run_pwm(2, 1, 20);
        run_pwm(200, 150, 4);

        repeat (300) step(1'b0);
        run_pwm(50, 20, 4);
        repeat (300) step(1'b1);
        run_pwm(60, 30, 3);

        run_pwm(255, 100, 3);
        run_pwm(256, 100, 3);
        run_pwm(255, 1, 2);

        for (int seg = 0; seg < 30; seg++) begin
            per = $urandom_range(300, 2);
            hi  = $urandom_range(per - 1, 1);
            run_pwm(per, hi, $urandom_range(4, 1));
        end

        // Asynchronous reset in mid-period, asserted between clock edges.
        run_pwm(40, 10, 3);
        run_pwm(40, 10, 0);
        repeat (17) step(1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pwm_i = ~pwm_i;
        end
        @(negedge clk);
        pwm_i = 1'b0;
        reset = 1'b1;
        model_reset();
        run_pwm(70, 35, 4);
        repeat (5) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
